// File: rtl/cond_check_pipe.sv
// cond_check_pipe: NZCV flag register plus a LATENCY-stage pipelined ARM
// condition-code evaluator with valid/ready handshakes and a pass-through tag.
//
// Parameters:
//   LATENCY  register stages from acceptance to rsp_valid (1..4)
//   TAG_W    width of the opaque request tag
//   FLAG_FWD 1: evaluate against flags written in the same cycle
//            0: evaluate against registered flags only
//
// Ports (flag vectors ordered [Z,C,N,V], bit3=Z .. bit0=V):
//   clk, rst_n           clock, async active-low reset
//   flags_we/_mask/_in   masked flag write port
//   flags_q              architectural flag register
//   req_valid/_ready     request handshake; req_cond, req_tag payload
//   rsp_valid/_ready     response handshake
//   rsp_taken            condition evaluated true
//   rsp_illegal          condition field was 4'b1111
//   rsp_tag              tag travelling with the response
//
// Build option: define COND_STATS_EN to add saturating taken_cnt and
// not_taken_cnt outputs counting response handshakes.

module cond_check_pipe #(
    parameter int LATENCY  = 1,
    parameter int TAG_W    = 4,
    parameter int FLAG_FWD = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flags_we,
    input  logic [3:0]       flags_mask,
    input  logic [3:0]       flags_in,
    output logic [3:0]       flags_q,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_cond,
    input  logic [TAG_W-1:0] req_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_taken,
    output logic             rsp_illegal,
    output logic [TAG_W-1:0] rsp_tag
`ifdef COND_STATS_EN
    ,
    output logic [15:0]      taken_cnt,
    output logic [15:0]      not_taken_cnt
`endif
);

    typedef struct packed {
        logic             valid;
        logic             taken;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } stage_t;

    localparam int LAST = LATENCY - 1;

    // ------------------------------------------------------------------
    // Condition evaluation
    // ------------------------------------------------------------------
    function automatic logic cond_taken(input logic [3:0] cond,
                                        input logic [3:0] f);
        logic z;
        logic c;
        logic n;
        logic v;
        logic res;
        z = f[3];
        c = f[2];
        n = f[1];
        v = f[0];
        res = 1'b0;
        case (cond)
            4'h0: res = z;
            4'h1: res = ~z;
            4'h2: res = c;
            4'h3: res = ~c;
            4'h4: res = n;
            4'h5: res = ~n;
            4'h6: res = v;
            4'h7: res = ~v;
            4'h8: res = c & ~z;
            4'h9: res = ~c | z;
            4'hA: res = (n == v);
            4'hB: res = (n != v);
            4'hC: res = ~z & (n == v);
            4'hD: res = z | (n != v);
            4'hE: res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Flag register
    // ------------------------------------------------------------------
    logic [3:0] flags_d;
    logic [3:0] flags_eff;

    always_comb begin
        flags_d = flags_q;
        if (flags_we) begin
            flags_d = (flags_q & ~flags_mask) | (flags_in & flags_mask);
        end
    end

    // Forwarding picks the merged value so a request issued alongside
    // a flag write sees the result of that write.
    always_comb begin
        flags_eff = flags_q;
        if (FLAG_FWD != 0) begin
            flags_eff = flags_d;
        end
    end

    // Flags update even while the pipe is frozen; in-flight results
    // were resolved at acceptance and are unaffected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline
    // ------------------------------------------------------------------
    stage_t stg_q [LATENCY];
    stage_t stg_d [LATENCY];
    stage_t in_stg;
    logic   stall;
    logic   accept;

    // Whole-pipe freeze: only the output stage decides, so bubbles
    // upstream are intentionally not squeezed out.
    assign stall     = stg_q[LAST].valid & ~rsp_ready;
    assign req_ready = ~stall;
    assign accept    = req_valid & ~stall;

    always_comb begin
        in_stg = '0;
        if (accept) begin
            in_stg.valid   = 1'b1;
            in_stg.taken   = cond_taken(req_cond, flags_eff);
            in_stg.illegal = (req_cond == 4'hF);
            in_stg.tag     = req_tag;
        end
    end

    always_comb begin
        for (int i = 0; i < LATENCY; i++) begin
            stg_d[i] = stg_q[i];
        end
        if (!stall) begin
            stg_d[0] = in_stg;
            for (int i = 1; i < LATENCY; i++) begin
                stg_d[i] = stg_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                stg_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LATENCY; i++) begin
                stg_q[i] <= stg_d[i];
            end
        end
    end

    assign rsp_valid   = stg_q[LAST].valid;
    assign rsp_taken   = stg_q[LAST].taken;
    assign rsp_illegal = stg_q[LAST].illegal;
    assign rsp_tag     = stg_q[LAST].tag;

`ifdef COND_STATS_EN
    // ------------------------------------------------------------------
    // Saturating response statistics
    // ------------------------------------------------------------------
    logic        rsp_hs;
    logic [15:0] taken_cnt_q;
    logic [15:0] taken_cnt_d;
    logic [15:0] not_taken_cnt_q;
    logic [15:0] not_taken_cnt_d;

    assign rsp_hs = rsp_valid & rsp_ready;

    // Illegal responses carry taken=0 and so land in not_taken_cnt.
    always_comb begin
        taken_cnt_d     = taken_cnt_q;
        not_taken_cnt_d = not_taken_cnt_q;
        if (rsp_hs) begin
            if (rsp_taken) begin
                if (taken_cnt_q != 16'hFFFF) begin
                    taken_cnt_d = taken_cnt_q + 16'd1;
                end
            end else begin
                if (not_taken_cnt_q != 16'hFFFF) begin
                    not_taken_cnt_d = not_taken_cnt_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt_q     <= 16'd0;
            not_taken_cnt_q <= 16'd0;
        end else begin
            taken_cnt_q     <= taken_cnt_d;
            not_taken_cnt_q <= not_taken_cnt_d;
        end
    end

    assign taken_cnt     = taken_cnt_q;
    assign not_taken_cnt = not_taken_cnt_q;
`endif

endmodule

// File: tb/tb_cond_check_pipe.sv
// tb_cond_check_pipe: scoreboard bench for cond_check_pipe.
// Main DUT uses LATENCY=3, FLAG_FWD=1; a second LATENCY=1, FLAG_FWD=0 copy.

module tb_cond_check_pipe;

    localparam int L  = 3;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flags_we;
    logic [3:0]    flags_mask;
    logic [3:0]    flags_in;
    logic [3:0]    flags_q;
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_cond;
    logic [TW-1:0] req_tag;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_taken;
    logic          rsp_illegal;
    logic [TW-1:0] rsp_tag;

    logic [3:0]    nf_flags_q;
    logic          nf_req_ready;
    logic          nf_rsp_valid;
    logic          nf_rsp_taken;
    logic          nf_rsp_illegal;
    logic [TW-1:0] nf_rsp_tag;

`ifdef COND_STATS_EN
    logic [15:0]   taken_cnt;
    logic [15:0]   not_taken_cnt;
    logic [15:0]   nf_taken_cnt;
    logic [15:0]   nf_not_taken_cnt;
`endif

    always #5 clk = ~clk;

    cond_check_pipe #(.LATENCY(L), .TAG_W(TW), .FLAG_FWD(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .flags_we(flags_we), .flags_mask(flags_mask),
        .flags_in(flags_in), .flags_q(flags_q),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cond(req_cond), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_taken(rsp_taken), .rsp_illegal(rsp_illegal),
        .rsp_tag(rsp_tag)
`ifdef COND_STATS_EN
        , .taken_cnt(taken_cnt), .not_taken_cnt(not_taken_cnt)
`endif
    );

    cond_check_pipe #(.LATENCY(1), .TAG_W(TW), .FLAG_FWD(0)) u_nf (
        .clk(clk), .rst_n(rst_n),
        .flags_we(flags_we), .flags_mask(flags_mask),
        .flags_in(flags_in), .flags_q(nf_flags_q),
        .req_valid(req_valid), .req_ready(nf_req_ready),
        .req_cond(req_cond), .req_tag(req_tag),
        .rsp_valid(nf_rsp_valid), .rsp_ready(1'b1),
        .rsp_taken(nf_rsp_taken), .rsp_illegal(nf_rsp_illegal),
        .rsp_tag(nf_rsp_tag)
`ifdef COND_STATS_EN
        , .taken_cnt(nf_taken_cnt), .not_taken_cnt(nf_not_taken_cnt)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Reference condition table, flags ordered [Z,C,N,V].
    function automatic logic [1:0] ref_eval(input logic [3:0] c,
                                            input logic [3:0] f);
        logic z, cy, n, v;
        {z, cy, n, v} = f;
        case (c)
            4'h0: return {z, 1'b0};
            4'h1: return {!z, 1'b0};
            4'h2: return {cy, 1'b0};
            4'h3: return {!cy, 1'b0};
            4'h4: return {n, 1'b0};
            4'h5: return {!n, 1'b0};
            4'h6: return {v, 1'b0};
            4'h7: return {!v, 1'b0};
            4'h8: return {cy && !z, 1'b0};
            4'h9: return {!cy || z, 1'b0};
            4'hA: return {n == v, 1'b0};
            4'hB: return {n != v, 1'b0};
            4'hC: return {!z && (n == v), 1'b0};
            4'hD: return {z || (n != v), 1'b0};
            4'hE: return 2'b10;
            default: return 2'b01;
        endcase
    endfunction

    typedef struct {
        logic          taken;
        logic          illegal;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          e;
    logic [3:0]    mflags = 4'h0;
    logic [3:0]    eff;
    logic [1:0]    r;
    logic          stall_prev = 1'b0;
    logic          sv_taken;
    logic          sv_ill;
    logic [TW-1:0] sv_tag;

    // Sample at negedge: what is visible now is what the next edge acts on.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (stall_prev) begin
                chk("hold_valid", rsp_valid, 1);
                chk("hold_taken", rsp_taken, sv_taken);
                chk("hold_illegal", rsp_illegal, sv_ill);
                chk("hold_tag", rsp_tag, sv_tag);
            end
            stall_prev = rsp_valid && !rsp_ready;
            sv_taken   = rsp_taken;
            sv_ill     = rsp_illegal;
            sv_tag     = rsp_tag;
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_rsp", rsp_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_tag", rsp_tag, e.tag);
                    chk("rsp_taken", rsp_taken, e.taken);
                    chk("rsp_illegal", rsp_illegal, e.illegal);
                end
            end
            eff = flags_we ? ((mflags & ~flags_mask) | (flags_in & flags_mask))
                           : mflags;
            if (req_valid && req_ready) begin
                r = ref_eval(req_cond, eff);
                exp_q.push_back('{r[1], r[0], req_tag});
            end
            if (flags_we) mflags = eff;
        end
    end

    always @(negedge rst_n) begin
        exp_q.delete();
        mflags     = 4'h0;
        stall_prev = 1'b0;
    end

    task automatic wflags(input logic [3:0] m, input logic [3:0] d);
        flags_we   = 1'b1;
        flags_mask = m;
        flags_in   = d;
        @(posedge clk);
        #1;
        flags_we = 1'b0;
    endtask

    // Hold the request until it is accepted; returns 1 after that edge.
    task automatic send(input logic [3:0] c, input logic [TW-1:0] t);
        logic acc;
        int   tries;
        req_valid = 1'b1;
        req_cond  = c;
        req_tag   = t;
        tries     = 0;
        acc       = 1'b0;
        while (!acc && tries < 100) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            #1;
            tries++;
        end
        if (!acc) chk("send_timeout", {31'd0, req_ready}, 1);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n      = 1'b0;
        flags_we   = 1'b0;
        flags_mask = 4'h0;
        flags_in   = 4'h0;
        req_valid  = 1'b0;
        req_cond   = 4'h0;
        req_tag    = '0;
        rsp_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_flags", flags_q, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_taken", rsp_taken, 0);
        chk("rst_illegal", rsp_illegal, 0);
        chk("rst_tag", rsp_tag, 0);
        chk("rst_ready", req_ready, 1);
`ifdef COND_STATS_EN
        chk("rst_tcnt", taken_cnt, 0);
        chk("rst_ntcnt", not_taken_cnt, 0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full write Z=1, then EQ with latency measurement.
        wflags(4'hF, 4'h8);
        chk("wr_full", flags_q, 4'h8);
        send(4'h0, 4'h5);
        req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 10);
        chk("latency", n, L);
        @(posedge clk);
        #1;
        drain();

        // Partial write clears V only.
        wflags(4'hF, 4'hF);
        wflags(4'h1, 4'h0);
        chk("wr_partial", flags_q, 4'hE);
        wflags(4'h0, 4'h0);
        chk("wr_mask0", flags_q, 4'hE);
        send(4'hB, 4'h1);
        send(4'hA, 4'h2);
        req_valid = 1'b0;
        drain();

        // Same-cycle flag write and request.
        wflags(4'hF, 4'h0);
        flags_we   = 1'b1;
        flags_mask = 4'h8;
        flags_in   = 4'h8;
        send(4'h0, 4'h3);
        flags_we  = 1'b0;
        req_valid = 1'b0;
        chk("nofwd_valid", nf_rsp_valid, 1);
        chk("nofwd_taken", nf_rsp_taken, 0);
        chk("nofwd_tag", nf_rsp_tag, 4'h3);
        chk("fwd_flags", flags_q, 4'h8);
        drain();

        // Sweep all codes against Z=0,C=1,N=1,V=0.
        wflags(4'hF, 4'h6);
        for (int i = 0; i < 16; i++) begin
            send(4'(i), TW'(i));
        end
        req_valid = 1'b0;
        drain();

        // Back-to-back tags with a two-cycle consumer stall.
        fork
            begin
                send(4'hE, 4'h1);
                send(4'hE, 4'h2);
                send(4'hE, 4'h3);
                req_valid = 1'b0;
            end
            begin
                @(posedge clk);
                @(posedge clk);
                #1;
                rsp_ready = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    @(posedge clk);
                    @(negedge clk);
                    chk("stall_ready", req_ready, 0);
                    chk("stall_valid", rsp_valid, 1);
                    chk("stall_tag", rsp_tag, 4'h1);
                end
                @(posedge clk);
                #1;
                rsp_ready = 1'b1;
            end
        join
        drain();

        // Reset with two requests in flight.
        send(4'hE, 4'h7);
        send(4'hE, 4'h8);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst_valid", rsp_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", rsp_valid, 0);
        chk("arst_flags", flags_q, 0);
        chk("arst_tag", rsp_tag, 0);
        chk("arst_taken", rsp_taken, 0);
`ifdef COND_STATS_EN
        chk("arst_tcnt", taken_cnt, 0);
        chk("arst_ntcnt", not_taken_cnt, 0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("no_stale", rsp_valid, 0);
        end
        @(posedge clk);
        #1;
        chk("post_rst_queue", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cond_check_pipe.md
Name: cond_check_pipe

Overview:
Parametrised successor to the single-cycle branch-condition checker. Holds the architectural NZCV flag register itself and accepts partial flag writes from the ALU. Evaluates all 16 ARM condition codes through a LATENCY-stage pipeline with valid/ready backpressure and a tag that travels with each request. Sits between decode (requester) and the PC-select / writeback-squash logic (consumer).

Parameters:
LATENCY, 1, number of register stages from request acceptance to rsp_valid (legal 1..4)
TAG_W, 4, width of the opaque tag carried with each request
FLAG_FWD, 1, 1 = request evaluated against flags being written in the same cycle; 0 = against registered flags only

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flags_we  in  1  flag write strobe
flags_mask  in  4  per-bit write enable, ordering [Z,C,N,V] (bit3=Z, bit2=C, bit1=N, bit0=V)
flags_in  in  4  new flag values, [Z,C,N,V]
flags_q  out  4  current flag register, [Z,C,N,V]
req_valid  in  1  condition request valid
req_ready  out  1  pipeline can accept a request
req_cond  in  4  ARM condition field
req_tag  in  TAG_W  tag returned with the result
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accepts result
rsp_taken  out  1  condition true
rsp_illegal  out  1  cond was 4'b1111
rsp_tag  out  TAG_W  tag of this result

Behaviour:
- Reset (async, rst_n=0): flags_q=4'b0000; all stage valid bits=0; rsp_valid=0, rsp_taken=0, rsp_illegal=0, rsp_tag=0. Reset asserted mid-operation discards every in-flight request, with no response produced.
- Flag write: on a clk edge with flags_we=1, flags_q[i] <= flags_in[i] where flags_mask[i]=1; other bits hold. flags_we=1 with mask 0 leaves the register unchanged.
- Effective flags used at acceptance: FLAG_FWD=1 uses the masked merge of flags_in into flags_q when flags_we=1 in the same cycle; otherwise flags_q.
- Evaluation happens once, at acceptance (req_valid & req_ready). The result is computed from the effective flags, and later flag writes do not alter in-flight results.
- Condition codes (Z,C,N,V):
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C
  - 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z
  - A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V)
  - E AL 1; F: taken=0, illegal=1
- Pipeline: LATENCY stages, each holding {valid, taken, illegal, tag}.
  - With no stalls, a request accepted at edge k gives rsp_valid=1 after edge k+LATENCY-1, i.e. visible in the cycle following that edge. LATENCY=1 means the result appears the cycle after acceptance.
  - Throughput is 1 request per cycle.
- Backpressure:
  - Stall = rsp_valid & !rsp_ready. On stall, every stage holds (whole-pipe freeze).
  - req_ready = !stall. This is combinational from rsp_valid/rsp_ready and independent of req_valid.
  - Bubbles are not compressed during a stall.
  - rsp_* outputs stay stable while rsp_valid=1 and rsp_ready=0.
- Simultaneous events: a flag write and a stall in the same cycle still update flags; the stalled request is unaffected.
- A request with req_valid=1 and req_ready=0 is not accepted, and the requester holds it.

Optional Feature:
Macro COND_STATS_EN.
- Defined: adds outputs taken_cnt [15:0] and not_taken_cnt [15:0].
  - Each counter increments on a response handshake (rsp_valid & rsp_ready) according to rsp_taken.
  - Illegal responses count as not-taken.
  - Counters saturate at 16'hFFFF and reset to 0 on rst_n.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then write flags_we=1, mask=4'b1111, flags_in=4'b1000; next cycle req cond=0 (EQ) -> rsp_taken=1 after LATENCY cycles, rsp_tag echoed.
- Partial write: flags_q=4'b1111, then write mask=4'b0001, flags_in=4'b0000 -> flags_q=4'b1110. Then cond=B (LT, N=1,V=0) -> taken=1; cond=A (GE) -> taken=0.
- FLAG_FWD=1: flags_q=0000; same cycle flags_we=1, mask=4'b1000, flags_in=4'b1000 and req cond=0 -> taken=1. With FLAG_FWD=0 the same stimulus gives taken=0.
- Sweep all 16 cond values against flags 4'b0110 (Z=0,C=1,N=1,V=0):
  - taken for NE, CS, MI, VC, HI, LT, LE, AL
  - not taken for the rest
  - F gives illegal=1
- LATENCY=3, back-to-back tags 1,2,3 with rsp_ready=0 from cycle 3 for 2 cycles:
  - req_ready=0 during the stall
  - rsp_tag=1 held stable
  - tags delivered in order 1,2,3 with no loss or duplication
- rst_n pulsed low with 2 requests in flight -> rsp_valid=0 immediately, flags_q=0000, no stale responses after release. COND_STATS_EN build: counters read 0.
